lcd_bus_sequencer: RTL and testbench

- Low-level HD44780-compatible LCD bus controller that sits below the LCD display wrapper and consumes its character/address/start handshake, returning busy.
- After reset it runs the power-up delay and a fixed four-command init sequence.
- It then serves single-character writes as a set-DDRAM-address command followed by a data write, generating RS/RW/EN timing and the post-command waits.

---
 rtl/lcd_pkg.sv | 62 ++++++
 rtl/lcd_bus_timer.sv | 36 +++
 rtl/lcd_bus_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780 bus sequencer:
//               state encoding, controller command bytes, init ROM and
//               DDRAM address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Sequencer state encoding (explicit 3-bit width)
    typedef logic [2:0] lcd_state_t;
    localparam lcd_state_t S_PWRUP = 3'd0;
    localparam lcd_state_t S_SETUP = 3'd1;
    localparam lcd_state_t S_EN_HI = 3'd2;
    localparam lcd_state_t S_WAIT  = 3'd3;
    localparam lcd_state_t S_IDLE  = 3'd4;

    // HD44780 command bytes
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    // DDRAM base address of each display row
    localparam logic [7:0] ROW0_BASE = 8'h00;
    localparam logic [7:0] ROW1_BASE = 8'h40;

    // Init ROM, issued in index order after the power-up delay
    localparam int         INIT_LEN   = 4;
    localparam logic [7:0] INIT_ROM_0 = CMD_FUNC_SET;
    localparam logic [7:0] INIT_ROM_1 = CMD_DISP_ON;
    localparam logic [7:0] INIT_ROM_2 = CMD_CLEAR;
    localparam logic [7:0] INIT_ROM_3 = CMD_ENTRY;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = INIT_ROM_0;
            2'd1:    cmd = INIT_ROM_1;
            2'd2:    cmd = INIT_ROM_2;
            default: cmd = INIT_ROM_3;
        endcase
        return cmd;
    endfunction

    // 7-bit DDRAM address of a (row, column) position
    function automatic logic [6:0] ddram_addr(input logic row, input logic [3:0] col);
        logic [7:0] base;
        base = row ? ROW1_BASE : ROW0_BASE;
        return base[6:0] | {3'b000, col};
    endfunction

    // Set-DDRAM-address command byte for a (row, column) position
    function automatic logic [7:0] ddram_cmd(input logic row, input logic [3:0] col);
        return CMD_SET_DDRAM | {1'b0, ddram_addr(row, col)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_timer
// Description : Wait timer shared by every sequencer state. Cleared on state
//               entry, counts elapsed cycles (saturating, never wraps) and
//               flags the last cycle of an i_limit-cycle interval.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_timer #(
    parameter int WIDTH = 21
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Elapsed-cycle counter, restarted on every state entry, holds at all-ones
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Current cycle is the last one of the requested interval (i_limit >= 1)
    assign o_done = (r_count == (i_limit - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_sequencer
// Description : HD44780 8-bit bus controller. Runs the power-up delay and the
//               four-command init sequence, then serves single-character
//               writes as set-DDRAM-address + data-write bus transactions.
//               Optional macro LCD_ADDR_SKIP_EN: track the LCD cursor and skip
//               the address phase when the request hits the current cursor.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP_CYC = 750000,
    parameter int T_EN_CYC    = 25,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_address,
    input  logic [7:0] i_character,
    output logic       o_busy,
    output logic       o_init_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_lcd_blon
);

    localparam int c_max_ab    = (T_PWRUP_CYC > T_EN_CYC)  ? T_PWRUP_CYC : T_EN_CYC;
    localparam int c_max_cd    = (T_CMD_CYC   > T_CLR_CYC) ? T_CMD_CYC   : T_CLR_CYC;
    localparam int c_max_cyc   = (c_max_ab    > c_max_cd)  ? c_max_ab    : c_max_cd;
    localparam int c_timer_w   = $clog2(c_max_cyc) + 1;

    localparam logic [c_timer_w-1:0] c_lim_pwrup = c_timer_w'(T_PWRUP_CYC);
    localparam logic [c_timer_w-1:0] c_lim_en    = c_timer_w'(T_EN_CYC);
    localparam logic [c_timer_w-1:0] c_lim_cmd   = c_timer_w'(T_CMD_CYC);
    localparam logic [c_timer_w-1:0] c_lim_clr   = c_timer_w'(T_CLR_CYC);
    localparam logic [c_timer_w-1:0] c_lim_one   = c_timer_w'(1);

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic [7:0]       r_lcd_data;
    logic [7:0]       w_data_nxt;
    logic             r_lcd_rs;
    logic             w_rs_nxt;
    logic             r_lcd_en;
    logic [1:0]       r_init_idx;
    logic [1:0]       w_idx_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_init_done;
    logic             w_init_done_nxt;
    logic [7:0]       r_char;
    logic             w_accept;
    logic             w_skip;
    logic             w_tmr_clear;
    logic [c_timer_w-1:0] w_tmr_limit;
    logic             w_tmr_done;
    logic             w_unused_addr;

    // Row/column fields only; the top three address bits carry no meaning
    assign w_unused_addr = &{1'b0, i_address[7:5]};

    // Interval length of the current state; clear/home need the long wait
    always_comb begin
        w_tmr_limit = c_lim_one;
        case (r_state)
            S_PWRUP: w_tmr_limit = c_lim_pwrup;
            S_EN_HI: w_tmr_limit = c_lim_en;
            S_WAIT:  w_tmr_limit = (!r_lcd_rs && (r_lcd_data == CMD_CLEAR || r_lcd_data == CMD_HOME))
                                   ? c_lim_clr : c_lim_cmd;
            default: w_tmr_limit = c_lim_one;
        endcase
    end

    assign w_tmr_clear = (w_state_nxt != r_state);

    lcd_bus_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_tmr_clear),
        .i_limit (w_tmr_limit),
        .o_done  (w_tmr_done)
    );

    // Next-state logic: init sequencing, address/data phases, request accept
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_lcd_data;
        w_rs_nxt        = r_lcd_rs;
        w_idx_nxt       = r_init_idx;
        w_busy_nxt      = r_busy;
        w_init_done_nxt = r_init_done;
        w_accept        = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_SETUP;
                    w_data_nxt  = init_cmd(2'd0);
                    w_rs_nxt    = 1'b0;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_EN_HI;
            end
            S_EN_HI: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_tmr_done) begin
                    if (!r_init_done) begin
                        if (r_init_idx == 2'(INIT_LEN - 1)) begin
                            w_state_nxt     = S_IDLE;
                            w_busy_nxt      = 1'b0;
                            w_init_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_SETUP;
                            w_idx_nxt   = r_init_idx + 2'd1;
                            w_data_nxt  = init_cmd(r_init_idx + 2'd1);
                        end
                    end else if (!r_lcd_rs) begin
                        // Address phase finished: move on to the data phase
                        w_state_nxt = S_SETUP;
                        w_data_nxt  = r_char;
                        w_rs_nxt    = 1'b1;
                    end else begin
                        // Data phase finished; busy drops one cycle later in idle
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (r_busy) begin
                    w_busy_nxt = 1'b0;
                end else if (i_start) begin
                    w_accept    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_SETUP;
                    if (w_skip) begin
                        w_data_nxt = i_character;
                        w_rs_nxt   = 1'b1;
                    end else begin
                        w_data_nxt = ddram_cmd(i_address[4], i_address[3:0]);
                        w_rs_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_PWRUP;
            end
        endcase
    end

    // State and bus registers; async reset aborts any transaction and drops EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_PWRUP;
            r_lcd_data  <= 8'h00;
            r_lcd_rs    <= 1'b0;
            r_lcd_en    <= 1'b0;
            r_init_idx  <= 2'd0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_char      <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_lcd_data  <= w_data_nxt;
            r_lcd_rs    <= w_rs_nxt;
            r_lcd_en    <= (w_state_nxt == S_EN_HI);
            r_init_idx  <= w_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_init_done <= w_init_done_nxt;
            if (w_accept) begin
                r_char <= i_character;
            end
        end
    end

`ifdef LCD_ADDR_SKIP_EN
    logic       r_cur_valid;
    logic [6:0] r_cur_addr;
    logic       r_row;
    logic [3:0] r_col;
    logic       w_data_done;

    assign w_skip      = r_cur_valid && (r_cur_addr == ddram_addr(i_address[4], i_address[3:0]));
    assign w_data_done = (r_state == S_WAIT) && w_tmr_done && r_init_done && r_lcd_rs;

    // Mirror the LCD's auto-incrementing cursor; unknown after reset/clear and
    // after the last cell of row 1, where the controller leaves the visible area
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cur_valid <= 1'b0;
            r_cur_addr  <= 7'h00;
            r_row       <= 1'b0;
            r_col       <= 4'h0;
        end else begin
            if (w_accept) begin
                r_row <= i_address[4];
                r_col <= i_address[3:0];
            end
            if (w_data_done) begin
                r_cur_valid <= !(r_row && (r_col == 4'hF));
                r_cur_addr  <= ddram_addr(r_row, r_col) + 7'd1;
            end
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    assign o_busy      = r_busy;
    assign o_init_done = r_init_done;
    assign o_lcd_data  = r_lcd_data;
    assign o_lcd_rs    = r_lcd_rs;
    assign o_lcd_en    = r_lcd_en;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_on    = 1'b1;
    assign o_lcd_blon  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_bus_sequencer
// Description : Scoreboard bench for lcd_bus_sequencer. Expected bus pulses
//               and busy durations are queued when stimulus is issued; a
//               monitor pops and compares on every EN pulse / busy fall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_sequencer;

    localparam int T_PW  = 20;
    localparam int T_EN  = 2;
    localparam int T_CMD = 5;
    localparam int T_CLR = 9;
`ifdef LCD_ADDR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] chr   = 8'h00;
    logic       busy, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_sequencer #(
        .T_PWRUP_CYC (T_PW),
        .T_EN_CYC    (T_EN),
        .T_CMD_CYC   (T_CMD),
        .T_CLR_CYC   (T_CLR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_start     (start),
        .i_address   (addr),
        .i_character (chr),
        .o_busy      (busy),
        .o_init_done (init_done),
        .o_lcd_data  (lcd_data),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_on    (lcd_on),
        .o_lcd_blon  (lcd_blon)
    );

    // gap = EN-low cycles before this pulse (-1 when it depends on idle time)
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;
    } bus_item_t;

    bus_item_t exp_q[$];
    int        busy_exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cursor   = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: init pulses and their waits
    task automatic push_init();
        exp_q.push_back('{8'h38, 1'b0, T_PW + 1});
        exp_q.push_back('{8'h0C, 1'b0, T_CMD + 1});
        exp_q.push_back('{8'h01, 1'b0, T_CMD + 1});
        exp_q.push_back('{8'h06, 1'b0, T_CLR + 1});
    endtask

    // Reference model: one write request in terms of DDRAM position
    task automatic push_write(input logic [7:0] a, input logic [7:0] c);
        int t;
        bit sk;
        t  = (a[4] ? 64 : 0) + int'(a[3:0]);
        sk = SKIP && (cursor == t);
        if (!sk) exp_q.push_back('{8'(128 + t), 1'b0, -1});
        exp_q.push_back('{c, 1'b1, sk ? -1 : T_CMD + 1});
        busy_exp_q.push_back(sk ? (1 + T_EN + T_CMD) + 1 : 2 * (1 + T_EN + T_CMD) + 1);
        cursor = (t == 64 + 15) ? -1 : t + 1;
    endtask

    task automatic noise();
        start = ($urandom_range(0, 2) == 0);
        addr  = 8'($urandom_range(0, 255));
        chr   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_init();
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (init_done && !busy) begin
                start = 1'b0;
                ok    = 1'b1;
                break;
            end
            noise();
        end
        start = 1'b0;
        if (!ok) check("init_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] c);
        bit ok = 1'b0;
        push_write(a, c);
        start = 1'b1;
        addr  = a;
        chr   = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                ok    = 1'b1;
                break;
            end
            noise();
        end
        start = 1'b0;
        if (!ok) check("write_timeout", 32'd0, 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic reset_mid_en(input logic [7:0] a, input logic [7:0] c);
        bit ok = 1'b0;
        push_write(a, c);
        start = 1'b1;
        addr  = a;
        chr   = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (lcd_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("en_timeout", 32'd0, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_en",        32'(lcd_en),    32'd0);
        check("abort_busy",      32'(busy),      32'd1);
        check("abort_init_done", 32'(init_done), 32'd0);
        check("abort_data",      32'(lcd_data),  32'd0);
        exp_q.delete();
        busy_exp_q.delete();
        cursor = -1;
        push_init();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_init();
    endtask

    // Monitor: compare each EN pulse and each busy window with the scoreboard
    logic en_prev   = 1'b0;
    logic busy_prev = 1'b1;
    bit   busy_run  = 1'b0;
    int   hi_len    = 0;
    int   lo_len    = 0;
    int   busy_len  = 0;

    always @(negedge clk) begin
        bus_item_t it;
        int        exp_len;
        if (!rst_n) begin
            en_prev   = 1'b0;
            busy_prev = 1'b1;
            busy_run  = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
            busy_len  = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_en_pulse", 32'd1, 32'd0);
                end else begin
                    it = exp_q.pop_front();
                    check("bus_data", 32'(lcd_data), 32'(it.data));
                    check("bus_rs",   32'(lcd_rs),   32'(it.rs));
                    check("bus_rw",   32'(lcd_rw),   32'd0);
                    if (it.gap >= 0) check("en_gap", 32'(lo_len), 32'(it.gap));
                end
                hi_len = 1;
            end else if (lcd_en) begin
                hi_len++;
            end else if (en_prev) begin
                check("en_width", 32'(hi_len), 32'(T_EN));
                lo_len = 1;
            end else begin
                lo_len++;
            end

            if (busy && !busy_prev) begin
                busy_run = 1'b1;
                busy_len = 1;
            end else if (busy && busy_run) begin
                busy_len++;
            end else if (!busy && busy_prev) begin
                if (busy_run) begin
                    if (busy_exp_q.size() == 0) begin
                        check("unexpected_busy", 32'd1, 32'd0);
                    end else begin
                        exp_len = busy_exp_q.pop_front();
                        check("busy_len", 32'(busy_len), 32'(exp_len));
                    end
                end else begin
                    check("init_done_at_ready", 32'(init_done), 32'd1);
                end
                busy_run = 1'b0;
            end
            en_prev   = lcd_en;
            busy_prev = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_data",      32'(lcd_data),  32'd0);
        check("rst_rs",        32'(lcd_rs),    32'd0);
        check("rst_rw",        32'(lcd_rw),    32'd0);
        check("rst_en",        32'(lcd_en),    32'd0);
        check("rst_on",        32'(lcd_on),    32'd1);
        check("rst_blon",      32'(lcd_blon),  32'd1);

        cursor = -1;
        push_init();
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_init();

        do_write(8'h13, 8'h41);
        do_write(8'h1F, 8'h5A);
        do_write(8'h00, 8'h30);
        do_write(8'h01, 8'h31);
        do_write(8'hE5, 8'h01);

        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            if (cursor >= 0 && (cursor % 64) < 16 && $urandom_range(0, 1) == 1) begin
                a[4]   = (cursor >= 64);
                a[3:0] = 4'(cursor % 16);
            end
            do_write(a, 8'($urandom_range(0, 255)));
        end

        reset_mid_en(8'h07, 8'h42);
        do_write(8'h10, 8'h43);
        do_write(8'h11, 8'h44);

        repeat (5) @(negedge clk);
        check("bus_queue_drained",  32'(exp_q.size()),      32'd0);
        check("busy_queue_drained", 32'(busy_exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
